// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg: shared types for the RAM block-transfer engine.
// FSM state encoding and transfer-mode constants.
package ram_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_dma_if.sv
// ram_dma_if: read/write port pair between the engine and d_ram.
// master = transfer engine, slave = RAM.
interface ram_dma_if #(
  parameter int addr_width = 8,
  parameter int data_width = 8
);

  logic [addr_width-1:0] r_addr;
  logic                  r_en;
  logic [data_width-1:0] rd_data;
  logic [addr_width-1:0] w_addr;
  logic                  w_en;
  logic [data_width-1:0] wr_data;

  modport master (
    output r_addr,
    output r_en,
    output w_addr,
    output w_en,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  r_addr,
    input  r_en,
    input  w_addr,
    input  w_en,
    input  wr_data,
    output rd_data
  );

endinterface

// File: rtl/ram_dma_addr_gen.sv
// dma_addr_gen: loadable address counter with remaining-word count.
// last flags the final word of the loaded run.
module dma_addr_gen #(
  parameter int addr_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [addr_width-1:0] ld_addr,
  input  logic [addr_width:0]   ld_cnt,
  output logic [addr_width-1:0] addr,
  output logic                  last
);

  logic [addr_width:0] cnt;

  // Load a new run, or advance one word (address wraps naturally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= ld_addr;
      cnt  <= ld_cnt;
    end else if (step) begin
      addr <= addr + addr_width'(1);
      cnt  <= cnt - (addr_width + 1)'(1);
    end
  end

  assign last = (cnt == (addr_width + 1)'(1));

endmodule

// File: rtl/ram_dma.sv
// ram_dma: single-channel RAM-to-RAM copy engine, one word per clock.
// Optional constant fill mode is built when DMA_FILL_EN is defined.
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode,
  input  logic [addr_width-1:0] src,
  input  logic [addr_width-1:0] dst,
  input  logic [addr_width:0]   len,
  input  logic [data_width-1:0] fill_val,
  output logic                  busy,
  output logic                  done,
  ram_dma_if.master             ram
);

  state_t state;

  logic                  issue;
  logic                  r_en_q;
  logic                  w_en_q;
  logic [addr_width-1:0] w_addr_q;
  logic [addr_width-1:0] delta;
  logic [addr_width-1:0] rd_addr;
  logic                  last;
  logic                  load;
  logic                  step;
  logic                  fill_in;

  assign load = (state == IDLE) && start && (len != '0);
  assign step = (state == RUN) && !last && !abort;

  dma_addr_gen #(
    .addr_width(addr_width)
  ) u_rd_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .ld_addr(src),
    .ld_cnt (len),
    .addr   (rd_addr),
    .last   (last)
  );

`ifdef DMA_FILL_EN
  logic                  fill_q;
  logic [data_width-1:0] fill_v;

  assign fill_in = (mode == MODE_FILL);

  // Hold mode and fill constant for the whole transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= 1'b0;
      fill_v <= '0;
    end else if (load) begin
      fill_q <= fill_in;
      fill_v <= fill_val;
    end
  end

  assign ram.wr_data = fill_q ? fill_v : ram.rd_data;
`else
  logic unused_cfg;

  assign unused_cfg  = ^{mode, fill_val};
  assign fill_in     = 1'b0;
  assign ram.wr_data = ram.rd_data;
`endif

  // Control FSM; write stage trails the read stage by one register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      issue    <= 1'b0;
      r_en_q   <= 1'b0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      delta    <= '0;
    end else begin
      done   <= 1'b0;
      w_en_q <= issue;
      if (issue) begin
        w_addr_q <= rd_addr + delta;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= RUN;
              issue  <= 1'b1;
              r_en_q <= ~fill_in;
              delta  <= dst - src;
            end
          end
        end
        RUN: begin
          if (last || abort) begin
            issue  <= 1'b0;
            r_en_q <= 1'b0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ram.r_addr = rd_addr;
  assign ram.r_en   = r_en_q;
  assign ram.w_addr = w_addr_q;
  assign ram.w_en   = w_en_q;

endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma: directed bench for ram_dma with a RAM model
// and a transfer-level reference of the RAM contents and port trace.
module tb_ram_dma;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       mode;
  logic [7:0] src;
  logic [7:0] dst;
  logic [8:0] len;
  logic [7:0] fill_val;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  ram_dma_if #(.addr_width(8), .data_width(8)) bus ();

  ram_dma #(
    .addr_width(8),
    .data_width(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .mode    (mode),
    .src     (src),
    .dst     (dst),
    .len     (len),
    .fill_val(fill_val),
    .busy    (busy),
    .done    (done),
    .ram     (bus)
  );

`ifdef DMA_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  // d_ram: registered read, write-before-nothing (old data on collision)
  always @(posedge clk) begin
    if (bus.w_en) mem[bus.w_addr] <= bus.wr_data;
    if (bus.r_en) bus.rd_data <= mem[bus.r_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  bit         chk_on = 1'b0;
  logic       exp_busy, exp_done, exp_ren, exp_wen;
  logic [7:0] exp_raddr, exp_waddr, exp_wdata;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("r_en", bus.r_en, exp_ren);
      chk("w_en", bus.w_en, exp_wen);
      if (exp_ren) chk("r_addr", bus.r_addr, exp_raddr);
      if (exp_wen) begin
        chk("w_addr", bus.w_addr, exp_waddr);
        chk("wr_data", bus.wr_data, exp_wdata);
      end
    end
  end

  task automatic xfer(input logic [7:0] s, input logic [7:0] d,
                      input int n, input bit m, input logic [7:0] fv,
                      input int ab, input int st2,
                      output int done_at, output int wr_cnt,
                      output int rd_cnt);
    logic [7:0] snap [256];
    int r;
    int dn;
    bit fl;
    fl = FILL_ON && m;
    snap = ref_mem;
    r = (n == 0) ? 0 : ((ab > 0 && ab < n) ? ab : n);
    dn = (n == 0) ? 1 : r + 2;
    for (int k = 0; k < r; k++)
      ref_mem[8'(d + k)] = fl ? fv : snap[8'(s + k)];
    done_at = -1;
    wr_cnt = 0;
    rd_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    src = s;
    dst = d;
    len = 9'(n);
    mode = m;
    fill_val = fv;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int t = 1; t <= dn + 1; t++) begin
      exp_busy  = (t <= dn);
      exp_done  = (t == dn);
      exp_ren   = !fl && (t <= r);
      exp_raddr = 8'(s + t - 1);
      exp_wen   = (t >= 2) && (t <= r + 1);
      exp_waddr = 8'(d + t - 2);
      exp_wdata = fl ? fv : snap[8'(s + t - 2)];
      chk_on = 1'b1;
      @(negedge clk);
      if (done === 1'b1 && done_at < 0) done_at = t;
      if (bus.w_en === 1'b1) wr_cnt++;
      if (bus.r_en === 1'b1) rd_cnt++;
      abort = (t == ab);
      if (t == st2) begin
        start = 1'b1;
        src = 8'h33;
        dst = 8'h77;
        len = 9'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    chk_on = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    for (int k = 0; k < r; k++)
      chk("dst_word", mem[8'(d + k)], ref_mem[8'(d + k)]);
    if (r < 256)
      chk("past_end", mem[8'(d + r)], ref_mem[8'(d + r)]);
  endtask

  initial begin
    int da, wc, rc;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode = 1'b0;
    src = '0;
    dst = '0;
    len = '0;
    fill_val = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h5C;
      ref_mem[i] = 8'(i) ^ 8'h5C;
    end
    for (int i = 0; i < 4; i++) begin
      mem[8'h10 + i] = 8'hA1 + 8'(i);
      ref_mem[8'h10 + i] = 8'hA1 + 8'(i);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_r_en", bus.r_en, 1'b0);
    chk("rst_w_en", bus.w_en, 1'b0);
    chk("rst_r_addr", bus.r_addr, 8'h00);
    chk("rst_w_addr", bus.w_addr, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    xfer(8'h10, 8'h80, 4, 1'b0, 8'h00, 0, 0, da, wc, rc);
    chk("copy_done_cyc", da, 6);
    chk("copy_writes", wc, 4);
    chk("copy_reads", rc, 4);
    chk("copy_w0", mem[8'h80], 8'hA1);
    chk("copy_w3", mem[8'h83], 8'hA4);

    xfer(8'h50, 8'h90, 0, 1'b0, 8'h00, 0, 0, da, wc, rc);
    chk("len0_done_cyc", da, 1);
    chk("len0_writes", wc, 0);
    chk("len0_reads", rc, 0);

    xfer(8'hFE, 8'h40, 4, 1'b0, 8'h00, 0, 0, da, wc, rc);
    chk("wrap_reads", rc, 4);
    chk("wrap_w0", mem[8'h40], 8'hA2);
    chk("wrap_w1", mem[8'h41], 8'hA3);
    chk("wrap_w2", mem[8'h42], 8'h5C);
    chk("wrap_w3", mem[8'h43], 8'h5D);

    xfer(8'h60, 8'hC0, 8, 1'b0, 8'h00, 3, 0, da, wc, rc);
    chk("abort_writes", wc, 3);
    chk("abort_reads", rc, 3);
    chk("abort_done_cyc", da, 5);

    xfer(8'h20, 8'hA0, 5, 1'b0, 8'h00, 0, 2, da, wc, rc);
    chk("restart_done_cyc", da, 7);
    chk("restart_writes", wc, 5);

    xfer(8'h08, 8'h20, 3, 1'b1, 8'h5A, 0, 0, da, wc, rc);
    chk("mode1_writes", wc, 3);
`ifdef DMA_FILL_EN
    chk("fill_reads", rc, 0);
    chk("fill_w0", mem[8'h20], 8'h5A);
    chk("fill_w2", mem[8'h22], 8'h5A);
`else
    chk("nofill_reads", rc, 3);
    chk("nofill_w0", mem[8'h20], 8'h54);
`endif

    xfer(8'h00, 8'h00, 256, 1'b0, 8'h00, 0, 0, da, wc, rc);
    chk("full_done_cyc", da, 258);
    chk("full_writes", wc, 256);

    @(negedge clk);
    start = 1'b1;
    src = 8'h10;
    dst = 8'hE0;
    len = 9'd8;
    mode = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_r_en", bus.r_en, 1'b1);
    chk("pre_rst_w_en", bus.w_en, 1'b1);
    chk("pre_rst_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_r_en", bus.r_en, 1'b0);
    chk("mid_rst_w_en", bus.w_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
